soc_system_button_ctrl: RTL and testbench

SOC_SYSTEM_BUTTON_CTRL -- requirements
Module: soc_system_button_ctrl

---
 rtl/soc_system_button_pkg.sv | 9 +
 rtl/soc_system_button_debounce.sv | 47 ++++
 rtl/soc_system_button_ctrl.sv | 56 +++++
 tb/tb_soc_system_button_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/soc_system_button_pkg.sv
// soc_system_button_pkg: register map and default sizing shared by the button controller
package soc_system_button_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_RESERVED = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;
endpackage

// File: rtl/soc_system_button_debounce.sv
// soc_system_button_debounce: one button's synchronizer, debounce filter (counter only with SOC_SYSTEM_BUTTON_DEBOUNCE_EN) and press detector
module soc_system_button_debounce
`ifdef SOC_SYSTEM_BUTTON_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = soc_system_button_pkg::DEFAULT_DEBOUNCE_CYCLES)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic db,
  output logic press
);
  logic s1, s2, db_prev;
  // two-flop synchronizer; idles released (high)
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
`ifdef SOC_SYSTEM_BUTTON_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] count;
  // db follows s2 only after an unbroken run of mismatches; any agreement restarts the run
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      db <= 1'b1;
    end else if (s2 == db) count <= '0;
    else if (count == CW'(DEBOUNCE_CYCLES)) begin
      db <= s2;
      count <= '0;
    end else count <= count + 1'b1;
`else
  // no filtering: db tracks the synchronized level
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) db <= 1'b1;
    else db <= s2;
`endif
  // one-clock-delayed db for falling-edge detection
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) db_prev <= 1'b1;
    else db_prev <= db;
  assign press = db_prev & ~db;
endmodule

// File: rtl/soc_system_button_ctrl.sv
// soc_system_button_ctrl: Avalon-MM button controller with edge capture and masked irq; SOC_SYSTEM_BUTTON_DEBOUNCE_EN enables debouncing
module soc_system_button_ctrl
  import soc_system_button_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] db, press, irq_mask, edge_capture, mask_nxt, clr, cap_nxt;
  logic wr, unused_wdata;
  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("soc_system_button_ctrl: WIDTH must be 1..32 and DEBOUNCE_CYCLES at least 1");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_btn
`ifdef SOC_SYSTEM_BUTTON_DEBOUNCE_EN
    soc_system_button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk(clk), .reset_n(reset_n), .raw(in_port[i]), .db(db[i]), .press(press[i])
    );
`else
    soc_system_button_debounce u_btn (
      .clk(clk), .reset_n(reset_n), .raw(in_port[i]), .db(db[i]), .press(press[i])
    );
`endif
  end
  assign unused_wdata = ^writedata;
  assign wr = chipselect & ~write_n;
  assign mask_nxt = (wr && address == ADDR_IRQ_MASK) ? writedata[WIDTH-1:0] : irq_mask;
  assign clr = (wr && address == ADDR_EDGE_CAPTURE) ? writedata[WIDTH-1:0] : '0;
  assign cap_nxt = (edge_capture & ~clr) | press;
  // mask and capture registers; a press wins over a same-clock clear, irq tracks the next state
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irq_mask <= '0;
      edge_capture <= '0;
      irq <= 1'b0;
    end else begin
      irq_mask <= mask_nxt;
      edge_capture <= cap_nxt;
      irq <= |(cap_nxt & mask_nxt);
    end
  // read mux registered every clock regardless of chipselect
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) readdata <= '0;
    else readdata <= address == ADDR_DATA ? 32'(db) :
                     address == ADDR_IRQ_MASK ? 32'(irq_mask) :
                     address == ADDR_EDGE_CAPTURE ? 32'(edge_capture) : '0;
endmodule

// File: tb/tb_soc_system_button_ctrl.sv
// tb_soc_system_button_ctrl: directed vectors with a queue scoreboard for the button controller
module tb_soc_system_button_ctrl;
  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1, irq;
  logic [1:0] address = 2'd0;
  logic [31:0] writedata = '0, readdata;
  logic [3:0] in_port = 4'hF;
  logic rd_req = 1'b0, irq_req = 1'b0, rd_vld = 1'b0, irq_vld = 1'b0;
  int passed = 0, total = 0;
  logic [31:0] q_exp[$];
  string q_name[$];
`ifdef SOC_SYSTEM_BUTTON_DEBOUNCE_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif
  always #5 clk = ~clk;
  soc_system_button_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );
  always @(posedge clk) begin
    rd_vld <= rd_req;
    irq_vld <= irq_req;
  end
  always @(negedge clk) if (rd_vld || irq_vld) begin
    logic [31:0] got, e;
    string nm;
    got = rd_vld ? readdata : {31'b0, irq};
    total++;
    if (q_exp.size() == 0) $display("FAIL unexpected_output: got 0x%0h with no expected entry queued", got);
    else begin
      e = q_exp.pop_front();
      nm = q_name.pop_front();
      if (got === e) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, e);
    end
  end
  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(logic [31:0] e, string nm);
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask
  task automatic rd(logic [1:0] a, logic [31:0] e, string nm);
    address = a;
    rd_req = 1'b1;
    push(e, nm);
    tick();
    rd_req = 1'b0;
  endtask
  task automatic irqchk(logic e, string nm);
    irq_req = 1'b1;
    push({31'b0, e}, nm);
    tick();
    irq_req = 1'b0;
  endtask
  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    tick(2);
    rd(2'd0, 32'h0, "rst_readdata");
    irqchk(1'b0, "rst_irq");
    reset_n = 1'b1;
    tick(3);
    rd(2'd0, 32'hF, "rst_data");
    rd(2'd1, 32'h0, "rst_mask");
    rd(2'd2, 32'h0, "rst_reserved");
    rd(2'd3, 32'h0, "rst_cap");
    in_port = 4'hE;
    tick(LAT);
    rd(2'd3, 32'h0, "press_before_lat");
    rd(2'd3, 32'h1, "press_at_lat");
    rd(2'd0, 32'hE, "press_data");
    irqchk(1'b0, "press_irq_masked");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, "w1c_bit0");
    in_port = 4'hF;
    tick(LAT + 2);
    rd(2'd0, 32'hF, "release_data");
    rd(2'd3, 32'h0, "release_no_capture");
`ifdef SOC_SYSTEM_BUTTON_DEBOUNCE_EN
    for (int i = 0; i < 10; i++) begin
      in_port = (i % 2 == 0) ? 4'hE : 4'hF;
      tick(2);
    end
    in_port = 4'hF;
    tick(LAT + 2);
    rd(2'd0, 32'hF, "bounce_data");
    rd(2'd3, 32'h0, "bounce_cap");
`else
    in_port = 4'hE;
    tick(2);
    in_port = 4'hF;
    tick(LAT + 2);
    rd(2'd3, 32'h1, "glitch_cap");
    wr(2'd3, 32'h1);
    rd(2'd3, 32'h0, "glitch_w1c");
`endif
    wr(2'd1, 32'h2);
    rd(2'd1, 32'h2, "mask_rd");
    in_port = 4'hD;
    tick(LAT - 1);
    irqchk(1'b0, "irq_before_lat");
    irqchk(1'b1, "irq_at_lat");
    wr(2'd3, 32'h2);
    irqchk(1'b0, "irq_after_w1c");
    rd(2'd3, 32'h0, "cap_after_w1c");
    in_port = 4'hF;
    tick(LAT + 2);
    in_port = 4'hB;
    tick(LAT);
    wr(2'd3, 32'h4);
    rd(2'd3, 32'h4, "collision_kept");
    wr(2'd1, 32'h4);
    irqchk(1'b1, "irq_bit2");
    reset_n = 1'b0;
    rd(2'd0, 32'h0, "rst_mid_readdata");
    irqchk(1'b0, "rst_mid_irq");
    in_port = 4'hF;
    tick();
    reset_n = 1'b1;
    tick(3);
    rd(2'd0, 32'hF, "rst_mid_data");
    rd(2'd1, 32'h0, "rst_mid_mask");
    rd(2'd2, 32'h0, "rst_mid_reserved");
    rd(2'd3, 32'h0, "rst_mid_cap");
    in_port = 4'h7;
    tick(2);
    reset_n = 1'b0;
    tick();
    in_port = 4'hF;
    tick();
    reset_n = 1'b1;
    tick(LAT + 2);
    rd(2'd3, 32'h0, "rst_partial_cap");
    in_port = 4'h7;
    tick(LAT);
    rd(2'd3, 32'h0, "b3_before_lat");
    rd(2'd3, 32'h8, "b3_at_lat");
    in_port = 4'hF;
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, 32'h0, "reserved_write");
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'hF, "mask_width");
    irqchk(1'b1, "irq_bit3");
    wr(2'd3, 32'hFFFF_FFFF);
    irqchk(1'b0, "irq_clear_all");
    rd(2'd3, 32'h0, "cap_clear_all");
    tick(2);
    if (q_exp.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q_exp.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
